alu_seq: RTL and testbench

- Parametrised, handshaked successor to the team's 8-bit combinational ALU.
- Registers operands on acceptance and returns result plus status flags over a valid/ready output channel.
- Keeps the existing 3-bit function encoding; adds an optional iterative multiply in the spare opcode.
- Sits between the operand-issue logic and the writeback stage of the datapath.

---
 rtl/alu_seq_pkg.sv | 26 ++
 rtl/alu_seq_mul.sv | 63 ++++++
 rtl/alu_seq.sv | 146 ++++++++++++++
 tb/tb_alu_seq.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// ============================================================================
// alu_seq_pkg : opcode encoding and FSM state type shared by alu_seq
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_seq_mul.sv
// ============================================================================
// alu_seq_mul : iterative shift-add multiplier, one bit of b per cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] c_one   = CW'(1);
  localparam logic [CW-1:0] c_steps = CW'(WIDTH);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_cnt;
  logic             r_run;
  logic [WIDTH-1:0] w_acc_next;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  // The final step's sum is handed out combinationally so the caller can
  // register it on the same edge the last bit is consumed.
  assign done = r_run && (r_cnt == c_one);
  assign p    = w_acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
    end else if (start) begin
      r_acc    <= '0;
      r_mcand  <= a;
      r_mplier <= b;
      r_cnt    <= c_steps;
      r_run    <= 1'b1;
    end else if (r_run) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - c_one;
      if (r_cnt == c_one) begin
        r_run <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// alu_seq : handshaked ALU; func 111 multiplies when ALU_SEQ_MUL_EN is defined
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       func,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             zero,
  output logic             carry,
  output logic             ovf
);

  localparam logic [WIDTH:0] c_width_lim = (WIDTH + 1)'(WIDTH);

  state_t           r_state;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dif;
  logic             w_big;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;
  logic             w_accept;
  logic             w_is_mul;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_p;

  assign w_accept = in_valid && in_ready;
  assign w_sum    = {1'b0, a} + {1'b0, b};
  assign w_dif    = {1'b0, a} - {1'b0, b};
  // Shift amounts are judged on the full b so large values flush to zero.
  assign w_big    = ({1'b0, b} >= c_width_lim);

`ifdef ALU_SEQ_MUL_EN
  assign w_is_mul = (func == OP_MUL);

  alu_seq_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk  (clk),
    .rst  (rst),
    .start(w_accept && w_is_mul),
    .a    (a),
    .b    (b),
    .done (w_mul_done),
    .p    (w_mul_p)
  );
`else
  assign w_is_mul   = 1'b0;
  assign w_mul_done = 1'b0;
  assign w_mul_p    = '0;
`endif

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (func)
      OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res   = w_dif[WIDTH-1:0];
        w_carry = w_dif[WIDTH];
        w_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (w_dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  w_res = a & b;
      OP_XOR:  w_res = a ^ b;
      OP_NOT:  w_res = ~a;
      OP_SHL:  w_res = w_big ? '0 : (a << b[SHW-1:0]);
      OP_SHR:  w_res = w_big ? '0 : (a >> b[SHW-1:0]);
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      c         <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            in_ready <= 1'b0;
            if (w_is_mul) begin
              r_state <= BUSY;
            end else begin
              r_state   <= DONE;
              out_valid <= 1'b1;
              c         <= w_res;
              zero      <= (w_res == '0);
              carry     <= w_carry;
              ovf       <= w_ovf;
            end
          end
        end
        BUSY: begin
          if (w_mul_done) begin
            r_state   <= DONE;
            out_valid <= 1'b1;
            c         <= w_mul_p;
            zero      <= (w_mul_p == '0);
            carry     <= 1'b0;
            ovf       <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state   <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// tb_alu_seq : scoreboard bench for alu_seq (WIDTH=8), honours ALU_SEQ_MUL_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_seq;

  localparam int W = 8;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] c;
    logic         z;
    logic         cy;
    logic         v;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   func;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] c;
  logic         zero;
  logic         carry;
  logic         ovf;

  res_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .func     (func),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .c        (c),
    .zero     (zero),
    .carry    (carry),
    .ovf      (ovf)
  );

  // Reference model built on integer arithmetic.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic [2:0] f);
    res_t r;
    int   s;
    int   sx;
    int   sy;
    r  = '0;
    sx = int'($signed(x));
    sy = int'($signed(y));
    case (f)
      3'd0: begin
        s = int'(x) + int'(y);
        r.c = s[W-1:0];
        r.cy = (s > 255);
        r.v = ((sx + sy) > 127) || ((sx + sy) < -128);
      end
      3'd1: begin
        s = int'(x) - int'(y);
        r.c = s[W-1:0];
        r.cy = (x < y);
        r.v = ((sx - sy) > 127) || ((sx - sy) < -128);
      end
      3'd2: r.c = x & y;
      3'd3: r.c = x ^ y;
      3'd4: r.c = ~x;
      3'd5: r.c = (int'(y) >= W) ? '0 : W'(int'(x) << int'(y));
      3'd6: r.c = (int'(y) >= W) ? '0 : W'(int'(x) >> int'(y));
      default: begin
        s = MUL_EN ? int'(x) * int'(y) : 0;
        r.c = s[W-1:0];
      end
    endcase
    r.z = (r.c == '0);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] f);
    int k = 0;
    while (!in_ready && k < 30) begin
      tick();
      k++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready: in_ready=%b required 1", in_ready);
    end
    a = x;
    b = y;
    func = f;
    in_valid = 1'b1;
    sb.push_back(model(x, y, f));
    tick();
    in_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    n_checks++;
    if (c !== '0) begin n_fail++; $display("FAIL reset_c: got %h required 00", c); end
    n_checks++;
    if ({zero, carry, ovf} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got z=%b cy=%b v=%b required 0 0 0", zero, carry, ovf);
    end
  endtask

  task automatic test_add();
    logic [W-1:0] xa[3] = '{8'h7F, 8'hFF, 8'h80};
    logic [W-1:0] ya[3] = '{8'h01, 8'h01, 8'h80};
    res_t e;
    int   n;
    for (int i = 0; i < 3; i++) begin
      send(xa[i], ya[i], 3'd0);
      wait_out(n);
      n_checks++;
      if (n != 0) begin n_fail++; $display("FAIL add_latency: got %0d required 1", n + 1); end
      e = sb.pop_front();
      n_checks++;
      if ({c, zero, carry, ovf} !== {e.c, e.z, e.cy, e.v}) begin
        n_fail++;
        $display("FAIL add_result: got c=%h z=%b cy=%b v=%b required c=%h z=%b cy=%b v=%b",
                 c, zero, carry, ovf, e.c, e.z, e.cy, e.v);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_sub_backpressure();
    res_t e;
    send(8'h03, 8'h05, 3'd1);
    e = sb.pop_front();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({out_valid, c, carry, zero, ovf} !== {1'b1, e.c, e.cy, e.z, e.v}) begin
        n_fail++;
        $display("FAIL sub_hold: cycle %0d got v=%b c=%h cy=%b required v=1 c=%h cy=%b",
                 i, out_valid, c, carry, e.c, e.cy);
      end
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL sub_in_ready_hold: got %b required 0", in_ready); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL sub_release: got in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    n_checks++;
    if (c !== e.c) begin n_fail++; $display("FAIL sub_idle_hold: got c=%h required %h", c, e.c); end
  endtask

  task automatic test_logic_shift();
    logic [W-1:0] xa[8] = '{8'h81, 8'h81, 8'hF0, 8'h5A, 8'h5A, 8'h5A, 8'h01, 8'h01};
    logic [W-1:0] ya[8] = '{8'd3,  8'd8,  8'd4,  8'h0F, 8'hFF, 8'h00, 8'd7,  8'hFF};
    logic [2:0]   fa[8] = '{3'd5,  3'd6,  3'd6,  3'd2,  3'd3,  3'd4,  3'd5,  3'd5};
    res_t e;
    int   n;
    for (int i = 0; i < 8; i++) begin
      send(xa[i], ya[i], fa[i]);
      wait_out(n);
      e = sb.pop_front();
      n_checks++;
      if ({c, zero, carry, ovf} !== {e.c, e.z, e.cy, e.v}) begin
        n_fail++;
        $display("FAIL op%0d_result a=%h b=%h: got c=%h z=%b cy=%b v=%b required c=%h z=%b cy=%b v=%b",
                 fa[i], xa[i], ya[i], c, zero, carry, ovf, e.c, e.z, e.cy, e.v);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] xa[2] = '{8'd13, 8'hFF};
    logic [W-1:0] ya[2] = '{8'd11, 8'hFF};
    res_t e;
    int   n;
    int   lat_req;
    lat_req = MUL_EN ? W + 1 : 1;
    for (int i = 0; i < 2; i++) begin
      send(xa[i], ya[i], 3'd7);
      wait_out(n);
      n_checks++;
      if (n + 1 != lat_req) begin n_fail++; $display("FAIL mul_latency: got %0d required %0d", n + 1, lat_req); end
      e = sb.pop_front();
      n_checks++;
      if ({c, zero, carry, ovf} !== {e.c, e.z, e.cy, e.v}) begin
        n_fail++;
        $display("FAIL mul_result: got c=%h z=%b cy=%b v=%b required c=%h z=%b cy=%b v=%b",
                 c, zero, carry, ovf, e.c, e.z, e.cy, e.v);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    res_t e;
    int   n;
    bit   seen;
    send(8'd13, 8'd11, 3'd7);
    tick();
    tick();
    tick();
    n_checks++;
    if ({in_ready, out_valid} !== {1'b0, !MUL_EN}) begin
      n_fail++; $display("FAIL mid_state: got in_ready=%b out_valid=%b required 0 %b", in_ready, out_valid, !MUL_EN);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    n_checks++;
    if ({in_ready, out_valid, c, zero, carry, ovf} !== {2'b10, 8'h00, 3'b000}) begin
      n_fail++; $display("FAIL mid_reset: got in_ready=%b out_valid=%b c=%h required 1 0 00", in_ready, out_valid, c);
    end
    seen = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL mid_discard: got stray out_valid=1 required 0"); end
    send(8'd2, 8'd3, 3'd0);
    wait_out(n);
    e = sb.pop_front();
    n_checks++;
    if ({out_valid, c} !== {1'b1, e.c}) begin
      n_fail++; $display("FAIL mid_after_add: got out_valid=%b c=%h required 1 %h", out_valid, c, e.c);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    res_t e;
    int   n;
    int   prev;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [2:0]   f;
    prev = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      x = W'($urandom);
      y = W'($urandom_range(0, 12));
      f = 3'($urandom_range(0, 6));
      send(x, y, f);
      n_checks++;
      if (i > 0 && acc_cyc - prev != 2) begin
        n_fail++; $display("FAIL b2b_spacing: got %0d cycles required 2", acc_cyc - prev);
      end
      prev = acc_cyc;
      wait_out(n);
      e = sb.pop_front();
      n_checks++;
      if ({c, zero, carry, ovf} !== {e.c, e.z, e.cy, e.v}) begin
        n_fail++;
        $display("FAIL b2b_result op%0d a=%h b=%h: got c=%h z=%b cy=%b v=%b required c=%h z=%b cy=%b v=%b",
                 f, x, y, c, zero, carry, ovf, e.c, e.z, e.cy, e.v);
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    func      = 3'd0;
    test_reset();
    test_add();
    test_sub_backpressure();
    test_logic_shift();
    test_mul();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
